// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : RV32I memory-stage load/store unit. Big-endian byte lanes.
//            Sub-word stores use read-modify-write. Optional macro
//            MISALIGN_TRAP_EN flags misaligned accesses.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata,
  output logic            stall,
  output logic            misalign,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_wd,
  input  logic [XLEN-1:0] mem_rd
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_merged;
  logic [XLEN-1:0] r_addr;

  logic            w_known;
  logic            w_byte;
  logic            w_half;
  logic            w_word;
  logic            w_trap;
  logic            w_go;
  logic [XLEN-1:0] w_word_addr;
  logic [XLEN-1:0] w_merged;
  logic [7:0]      w_byte_val;
  logic [15:0]     w_half_val;

  assign w_known     = req_valid && (funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
  assign w_byte      = (funct3[1:0] == 2'b00);
  assign w_half      = (funct3[1:0] == 2'b01);
  assign w_word      = (funct3 == 3'd2);
  assign w_word_addr = {addr[XLEN-1:2], 2'b00};

`ifdef MISALIGN_TRAP_EN
  assign w_trap = w_known && ((w_half && addr[0]) || (w_word && (addr[1:0] != 2'b00)));
`else
  assign w_trap = 1'b0;
`endif

  assign w_go = w_known && !w_trap && (r_state == S_IDLE);

  // Offset 0 is the most significant lane of the word.
  always_comb begin
    w_byte_val = mem_rd[7:0];
    case (addr[1:0])
      2'd0:    w_byte_val = mem_rd[31:24];
      2'd1:    w_byte_val = mem_rd[23:16];
      2'd2:    w_byte_val = mem_rd[15:8];
      default: w_byte_val = mem_rd[7:0];
    endcase
    w_half_val = addr[1] ? mem_rd[15:0] : mem_rd[31:16];
  end

  always_comb begin
    w_merged = mem_rd;
    if (w_byte) begin
      case (addr[1:0])
        2'd0:    w_merged[31:24] = wdata[7:0];
        2'd1:    w_merged[23:16] = wdata[7:0];
        2'd2:    w_merged[15:8]  = wdata[7:0];
        default: w_merged[7:0]   = wdata[7:0];
      endcase
    end else if (addr[1]) begin
      w_merged[15:0] = wdata[15:0];
    end else begin
      w_merged[31:16] = wdata[15:0];
    end
  end

  always_comb begin
    rdata    = '0;
    stall    = 1'b0;
    misalign = 1'b0;
    mem_we   = 1'b0;
    mem_wd   = wdata;
    mem_addr = w_word_addr;
    if (rst) begin
      mem_we = 1'b0;
    end else if (r_state == S_WRITE) begin
      mem_we   = 1'b1;
      mem_wd   = r_merged;
      mem_addr = r_addr;
    end else begin
      misalign = w_trap;
      if (w_go) begin
        if (!req_we) begin
          case (funct3)
            3'd0:    rdata = {{24{w_byte_val[7]}}, w_byte_val};
            3'd1:    rdata = {{16{w_half_val[15]}}, w_half_val};
            3'd4:    rdata = {24'd0, w_byte_val};
            3'd5:    rdata = {16'd0, w_half_val};
            default: rdata = mem_rd;
          endcase
        end else if (w_word) begin
          mem_we = 1'b1;
        end else begin
          stall = 1'b1;
        end
      end
    end
  end

  // A reset landing in WRITE drops the pending merged word unwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_merged <= '0;
      r_addr   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_go && req_we && !w_word) begin
            r_merged <= w_merged;
            r_addr   <= w_word_addr;
            r_state  <= S_WRITE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Self-checking bench for load_store_unit with a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        stall;
  logic        misalign;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem     [0:15];
  logic [31:0] ref_mem [0:15];

  typedef struct {
    logic [31:0] a;
    logic [31:0] w;
  } wr_t;
  wr_t pend_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  bit          lit_en = 1'b0;
  string       lit_name = "";
  logic [31:0] lit_r, lit_wd, lit_a;
  bit          lit_s, lit_we, lit_mis;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .misalign(misalign), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  assign mem_rd = mem[mem_addr[5:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[5:2]] <= mem_wd;

  function automatic void decode(output bit known, output bit trap);
    known = req_valid && (funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    trap  = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (known && (funct3 == 3'd1 || funct3 == 3'd5) && addr[0]) trap = 1'b1;
    if (known && funct3 == 3'd2 && addr[1:0] != 2'b00) trap = 1'b1;
`endif
  endfunction

  function automatic int lane_shift();
    if (funct3[1:0] == 2'b00) return 8 * (3 - int'(addr[1:0]));
    return 16 * (1 - int'(addr[1]));
  endfunction

  function automatic void model(output logic [31:0] r, output bit s, output bit we,
                                output bit mis, output logic [31:0] wd, output logic [31:0] a);
    bit known, trap;
    logic [31:0] w, lane;
    r = 0; s = 0; we = 0; mis = 0; wd = 0; a = addr & ~32'd3;
    if (rst) return;
    if (pend_q.size() != 0) begin
      we = 1; wd = pend_q[0].w; a = pend_q[0].a;
      return;
    end
    decode(known, trap);
    mis = trap;
    if (!known || trap) return;
    w = ref_mem[addr[5:2]];
    if (!req_we) begin
      lane = w >> lane_shift();
      case (funct3)
        3'd0: r = (lane & 32'hFF) | ((lane & 32'h80) != 0 ? 32'hFFFFFF00 : 32'h0);
        3'd1: r = (lane & 32'hFFFF) | ((lane & 32'h8000) != 0 ? 32'hFFFF0000 : 32'h0);
        3'd4: r = lane & 32'hFF;
        3'd5: r = lane & 32'hFFFF;
        default: r = w;
      endcase
    end else if (funct3 == 3'd2) begin
      we = 1; wd = wdata;
    end else begin
      s = 1;
    end
  endfunction

  // Reference state advances on the same edges the memory sees.
  always @(posedge clk or posedge rst) begin
    bit known, trap;
    logic [31:0] mask, w;
    wr_t e;
    if (rst) begin
      pend_q.delete();
    end else if (pend_q.size() != 0) begin
      ref_mem[pend_q[0].a[5:2]] = pend_q[0].w;
      pend_q.delete();
    end else begin
      decode(known, trap);
      if (known && !trap && req_we) begin
        if (funct3 == 3'd2) begin
          ref_mem[addr[5:2]] = wdata;
        end else begin
          mask = ((funct3[1:0] == 2'b00) ? 32'hFF : 32'hFFFF);
          w = ref_mem[addr[5:2]];
          e.a = addr & ~32'd3;
          e.w = (w & ~(mask << lane_shift())) | ((wdata & mask) << lane_shift());
          pend_q.push_back(e);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] er, ewd, ea;
    bit es, ewe, emis;
    model(er, es, ewe, emis, ewd, ea);
    n_tests++;
    if (rdata !== er || stall !== es || mem_we !== ewe || misalign !== emis ||
        (ewe && (mem_wd !== ewd || mem_addr !== ea))) begin
      n_fail++;
      $display("FAIL model t=%0t: got rdata=%h stall=%b we=%b mis=%b wd=%h a=%h, want rdata=%h stall=%b we=%b mis=%b wd=%h a=%h",
               $time, rdata, stall, mem_we, misalign, mem_wd, mem_addr, er, es, ewe, emis, ewd, ea);
    end
    if (lit_en) begin
      n_tests++;
      if (rdata !== lit_r || stall !== lit_s || mem_we !== lit_we || misalign !== lit_mis ||
          (lit_we && (mem_wd !== lit_wd || mem_addr !== lit_a))) begin
        n_fail++;
        $display("FAIL %s: got rdata=%h stall=%b we=%b mis=%b wd=%h a=%h, want rdata=%h stall=%b we=%b mis=%b wd=%h a=%h",
                 lit_name, rdata, stall, mem_we, misalign, mem_wd, mem_addr,
                 lit_r, lit_s, lit_we, lit_mis, lit_wd, lit_a);
      end
    end
  end

  task automatic cyc(input string nm, input bit r, input bit v, input bit we,
                     input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     input bit le, input logic [31:0] er, input bit es, input bit ewe,
                     input bit emis, input logic [31:0] ewd, input logic [31:0] ea);
    @(posedge clk);
    #1;
    rst = r; req_valid = v; req_we = we; funct3 = f3; addr = a; wdata = wd;
    lit_name = nm; lit_en = le; lit_r = er; lit_s = es; lit_we = ewe;
    lit_mis = emis; lit_wd = ewd; lit_a = ea;
    @(negedge clk);
    #1 lit_en = 1'b0;
  endtask

  initial begin
    cyc("reset_idle", 1, 0, 0, 3'd0, 32'h0, 32'h0, 1, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    cyc("reset_sw_blocked", 1, 1, 1, 3'd2, 32'h10, 32'h81223344, 1, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    cyc("sw_init", 0, 1, 1, 3'd2, 32'h10, 32'h81223344, 1, 32'h0, 0, 1, 0, 32'h81223344, 32'h10);
    cyc("lb_10", 0, 1, 0, 3'd0, 32'h10, 32'h0, 1, 32'hFFFFFF81, 0, 0, 0, 32'h0, 32'h0);
    cyc("lbu_10", 0, 1, 0, 3'd4, 32'h10, 32'h0, 1, 32'h00000081, 0, 0, 0, 32'h0, 32'h0);
    cyc("lb_13", 0, 1, 0, 3'd0, 32'h13, 32'h0, 1, 32'h00000044, 0, 0, 0, 32'h0, 32'h0);
    cyc("lh_10", 0, 1, 0, 3'd1, 32'h10, 32'h0, 1, 32'hFFFF8122, 0, 0, 0, 32'h0, 32'h0);
    cyc("lhu_12", 0, 1, 0, 3'd5, 32'h12, 32'h0, 1, 32'h00003344, 0, 0, 0, 32'h0, 32'h0);
    cyc("lw_10", 0, 1, 0, 3'd2, 32'h10, 32'h0, 1, 32'h81223344, 0, 0, 0, 32'h0, 32'h0);
    cyc("sw_11223344", 0, 1, 1, 3'd2, 32'h10, 32'h11223344, 1, 32'h0, 0, 1, 0, 32'h11223344, 32'h10);
    cyc("sb_stall", 0, 1, 1, 3'd0, 32'h11, 32'hAABBCCDD, 1, 32'h0, 1, 0, 0, 32'h0, 32'h0);
    cyc("sb_write", 0, 1, 1, 3'd0, 32'h11, 32'hAABBCCDD, 1, 32'h0, 0, 1, 0, 32'h11DD3344, 32'h10);
    cyc("lw_after_sb", 0, 1, 0, 3'd2, 32'h10, 32'h0, 1, 32'h11DD3344, 0, 0, 0, 32'h0, 32'h0);
    cyc("sw_deadbeef", 0, 1, 1, 3'd2, 32'h10, 32'hDEADBEEF, 1, 32'h0, 0, 1, 0, 32'hDEADBEEF, 32'h10);
    cyc("lw_deadbeef", 0, 1, 0, 3'd2, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0, 0, 0, 32'h0, 32'h0);
    cyc("sw_14", 0, 1, 1, 3'd2, 32'h14, 32'hA5A5A5A5, 1, 32'h0, 0, 1, 0, 32'hA5A5A5A5, 32'h14);
    cyc("sh14_stall", 0, 1, 1, 3'd1, 32'h14, 32'h00001234, 1, 32'h0, 1, 0, 0, 32'h0, 32'h0);
    cyc("sh14_write", 0, 1, 1, 3'd1, 32'h14, 32'h00001234, 1, 32'h0, 0, 1, 0, 32'h1234A5A5, 32'h14);
    cyc("sh16_stall", 0, 1, 1, 3'd1, 32'h16, 32'h00005678, 1, 32'h0, 1, 0, 0, 32'h0, 32'h0);
    cyc("sh16_write", 0, 1, 1, 3'd1, 32'h16, 32'h00005678, 1, 32'h0, 0, 1, 0, 32'h12345678, 32'h14);
    cyc("lw_14", 0, 1, 0, 3'd2, 32'h14, 32'h0, 1, 32'h12345678, 0, 0, 0, 32'h0, 32'h0);
    cyc("sw_restore", 0, 1, 1, 3'd2, 32'h10, 32'h11223344, 1, 32'h0, 0, 1, 0, 32'h11223344, 32'h10);
    cyc("sh_rst_stall", 0, 1, 1, 3'd1, 32'h12, 32'h0000CAFE, 1, 32'h0, 1, 0, 0, 32'h0, 32'h0);
    cyc("sh_rst_abandon", 1, 1, 1, 3'd1, 32'h12, 32'h0000CAFE, 1, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    cyc("post_rst_idle", 0, 0, 0, 3'd0, 32'h0, 32'h0, 1, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    cyc("lw_unchanged", 0, 1, 0, 3'd2, 32'h10, 32'h0, 1, 32'h11223344, 0, 0, 0, 32'h0, 32'h0);
`ifdef MISALIGN_TRAP_EN
    cyc("lw_11_trap", 0, 1, 0, 3'd2, 32'h11, 32'h0, 1, 32'h0, 0, 0, 1, 32'h0, 32'h0);
    cyc("lh_13_trap", 0, 1, 0, 3'd1, 32'h13, 32'h0, 1, 32'h0, 0, 0, 1, 32'h0, 32'h0);
    cyc("sh_13_trap", 0, 1, 1, 3'd1, 32'h13, 32'h0000BEEF, 1, 32'h0, 0, 0, 1, 32'h0, 32'h0);
    cyc("sw_11_trap", 0, 1, 1, 3'd2, 32'h11, 32'hCAFEF00D, 1, 32'h0, 0, 0, 1, 32'h0, 32'h0);
    cyc("lw_after_trap", 0, 1, 0, 3'd2, 32'h10, 32'h0, 1, 32'h11223344, 0, 0, 0, 32'h0, 32'h0);
`else
    cyc("lw_11_notrap", 0, 1, 0, 3'd2, 32'h11, 32'h0, 1, 32'h11223344, 0, 0, 0, 32'h0, 32'h0);
    cyc("lh_13_notrap", 0, 1, 0, 3'd1, 32'h13, 32'h0, 1, 32'h00003344, 0, 0, 0, 32'h0, 32'h0);
`endif
    cyc("noop_f3_3", 0, 1, 0, 3'd3, 32'h10, 32'h0, 1, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    cyc("noop_invalid", 0, 0, 0, 3'd2, 32'h10, 32'h0, 1, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    cyc("noop_f3_7_st", 0, 1, 1, 3'd7, 32'h10, 32'hFFFFFFFF, 1, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    cyc("lw_final", 0, 1, 0, 3'd2, 32'h10, 32'h0, 1, 32'h11223344, 0, 0, 0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; memory writes and all state update on posedge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  memory-stage request present.
REQ-005 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-006 SHALL have port funct3  input  3  RV32I width code: 0 b, 1 h, 2 w, 4 bu, 5 hu.
REQ-007 SHALL have port addr  input  32  byte address from ALU.
REQ-008 SHALL have port wdata  input  32  store data, rs2 value.
REQ-009 SHALL have port rdata  output  32  extended load result to writeback.
REQ-010 SHALL have port stall  output  1  freeze fetch..memory stages this cycle.
REQ-011 SHALL have port misalign  output  1  misaligned-access flag (see REQ-027).
REQ-012 SHALL have port mem_addr  output  32  word address to data memory, low 2 bits always 0.
REQ-013 SHALL have port mem_we  output  1  data-memory word write enable.
REQ-014 SHALL have port mem_wd  output  32  data-memory write word.
REQ-015 SHALL have port mem_rd  input  32  data-memory combinational read word.

Function
REQ-016 Byte lanes SHALL be big-endian within a word: offset 0 = mem_rd[31:24], offset 3 = mem_rd[7:0]; halfword offset 0 = [31:16], offset 2 = [15:0].
REQ-017 Loads SHALL complete combinationally in the request cycle, with no stall; lb/lh sign-extend, lbu/lhu zero-extend, lw passes the word.
REQ-018 Aligned sw SHALL drive mem_we=1, mem_wd=wdata, mem_addr={addr[31:2],00} in the request cycle, with no stall.
REQ-019 sb/sh SHALL use read-modify-write through a 2-state FSM, IDLE -> WRITE -> IDLE.
REQ-020 IDLE with sb/sh: stall=1, mem_we=0; register the merged word (mem_rd with the addressed lane replaced by wdata[7:0] or wdata[15:0]) and the word address; next state WRITE.
REQ-021 WRITE: stall=0, mem_we=1, mem_wd=merged register, mem_addr=registered address; the held request inputs SHALL be ignored; next state IDLE unconditionally.
REQ-022 Sub-word store latency SHALL be 2 cycles, with exactly one stall cycle; back-to-back sub-word stores SHALL each take 2 cycles.
REQ-023 req_valid=0 or funct3 in {3,6,7} SHALL produce a no-op: mem_we=0, stall=0, rdata=0.
REQ-024 rdata SHALL be 0 whenever no valid load is presented.

Reset
REQ-025 While rst=1: state=IDLE, merged and address registers=0, stall=0, mem_we=0, misalign=0.
REQ-026 rst asserted in WRITE SHALL abandon the write (mem_we=0 immediately); the memory word SHALL be unchanged.

Configuration
REQ-027 With macro MISALIGN_TRAP_EN defined, the flag condition SHALL be h/hu/sh with addr[0]=1, or w/sw with addr[1:0]!=0.
REQ-028 With MISALIGN_TRAP_EN defined, a flagged access SHALL set misalign=1 combinationally, force mem_we=0, stall=0, rdata=0, and not enter WRITE.
REQ-029 Without MISALIGN_TRAP_EN: misalign SHALL be tied 0; halfword accesses SHALL ignore addr[0] and word accesses SHALL ignore addr[1:0].

Verification
REQ-030 Memory word at 0x10 = 0x81223344: lb 0x10 -> rdata 0xFFFFFF81; lbu 0x10 -> 0x00000081; lb 0x13 -> 0x00000044.
REQ-031 Same word: lh 0x10 -> 0xFFFF8122; lhu 0x12 -> 0x00003344; lw 0x10 -> 0x81223344, stall=0.
REQ-032 Word at 0x10 = 0x11223344, sb 0x11 with wdata 0xAABBCCDD -> cycle 1 stall=1, mem_we=0; cycle 2 mem_we=1, mem_addr=0x10, mem_wd=0x11DD3344; following lw 0x10 -> 0x11DD3344.
REQ-033 sw 0x10 with wdata 0xDEADBEEF -> mem_we=1 and stall=0 in the same cycle; next lw 0x10 -> 0xDEADBEEF.
REQ-034 sh 0x12 with wdata 0x0000CAFE, rst pulsed during the WRITE cycle -> mem_we=0, word stays 0x11223344, state IDLE after reset.
REQ-035 lw 0x11 on word 0x11223344 -> with MISALIGN_TRAP_EN: misalign=1, rdata=0, no write; without it: misalign=0, rdata=0x11223344.
